dcache_mem_responder: RTL

DCACHE_MEM_RESPONDER -- requirements
Module: dcache_mem_responder

---
 rtl/dcache_mem_responder.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/dcache_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_mem_responder
//  Description : Line-granular backing memory for a D-cache. Requests are
//                queued in order, serviced one at a time after a fixed
//                latency; reads return a tagged line, writes are silent.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_mem_responder #(
    parameter  int LINE_BYTE_NUM = 8,
    parameter  int MSHR_NUM      = 2,
    parameter  int MEM_LINE_NUM  = 1024,
    parameter  int LATENCY       = 4,
    parameter  int QUEUE_DEPTH   = 4,
    localparam int ID_W          = (MSHR_NUM > 1) ? $clog2(MSHR_NUM) : 1,
    localparam int DATA_W        = LINE_BYTE_NUM * 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memReqValid,
    output logic              memReqReady,
    input  logic              memReqWE,
    input  logic [31:0]       memReqAddr,
    input  logic [DATA_W-1:0] memReqData,
    input  logic [ID_W-1:0]   memReqId,
    output logic              memRespValid,
    input  logic              memRespReady,
    output logic [ID_W-1:0]   memRespId,
    output logic [DATA_W-1:0] memRespData
);

    localparam int OFF_W = $clog2(LINE_BYTE_NUM);
    localparam int IDX_W = (MEM_LINE_NUM > 1) ? $clog2(MEM_LINE_NUM) : 1;
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Request FIFO storage
    logic              fifo_we_q   [QUEUE_DEPTH];
    logic [IDX_W-1:0]  fifo_idx_q  [QUEUE_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [QUEUE_DEPTH];
    logic [ID_W-1:0]   fifo_id_q   [QUEUE_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Backing store, deliberately never reset
    logic [DATA_W-1:0] mem_q [MEM_LINE_NUM];

    // FSM and in-flight request
    state_t            state_q;
    logic [LAT_W-1:0]  cnt_q;
    logic              cur_we_q;
    logic [IDX_W-1:0]  cur_idx_q;
    logic [DATA_W-1:0] cur_data_q;
    logic [ID_W-1:0]   cur_id_q;
    logic              resp_valid_q;
    logic [ID_W-1:0]   resp_id_q;
    logic [DATA_W-1:0] resp_data_q;

    logic              w_full;
    logic              w_empty;
    logic              w_enq;
    logic              w_deq;
    logic              w_store_we;
    logic [IDX_W-1:0]  w_req_idx;
    logic              w_unused_addr;

    // Only the line-index field of the address matters; the rest is folded
    // into a sink so offset/upper bits are visibly ignored.
    assign w_req_idx     = memReqAddr[OFF_W +: IDX_W];
    assign w_unused_addr = ^memReqAddr;

    assign w_full  = (count_q == CNT_W'(QUEUE_DEPTH));
    assign w_empty = (count_q == '0);

    // Ready depends only on the registered count: a pop in the same cycle
    // does not open a slot until the following cycle.
    assign memReqReady = !w_full && !rst;
    assign w_enq       = memReqValid && memReqReady;
    assign w_deq       = (state_q == S_IDLE) && !w_empty;

    assign wr_ptr_d = !w_enq ? wr_ptr_q :
                      (wr_ptr_q == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    assign rd_ptr_d = !w_deq ? rd_ptr_q :
                      (rd_ptr_q == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    assign count_d  = count_q + CNT_W'(w_enq) - CNT_W'(w_deq);

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO payload write on enqueue
    always_ff @(posedge clk) begin
        if (w_enq) begin
            fifo_we_q[wr_ptr_q]   <= memReqWE;
            fifo_idx_q[wr_ptr_q]  <= w_req_idx;
            fifo_data_q[wr_ptr_q] <= memReqData;
            fifo_id_q[wr_ptr_q]   <= memReqId;
        end
    end

    // Write completion commits to the store; suppressed while in reset
    assign w_store_we = !rst && (state_q == S_WAIT) && (cnt_q == '0) && cur_we_q;

    // Backing store update
    always_ff @(posedge clk) begin
        if (w_store_we) begin
            mem_q[cur_idx_q] <= cur_data_q;
        end
    end

    // Service FSM: pop, count down the latency, then commit or respond
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            cur_we_q     <= 1'b0;
            cur_idx_q    <= '0;
            cur_data_q   <= '0;
            cur_id_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_deq) begin
                        cur_we_q   <= fifo_we_q[rd_ptr_q];
                        cur_idx_q  <= fifo_idx_q[rd_ptr_q];
                        cur_data_q <= fifo_data_q[rd_ptr_q];
                        cur_id_q   <= fifo_id_q[rd_ptr_q];
                        cnt_q      <= LAT_W'(LATENCY - 1);
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        if (cur_we_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            resp_valid_q <= 1'b1;
                            resp_id_q    <= cur_id_q;
                            resp_data_q  <= mem_q[cur_idx_q];
                            state_q      <= S_RESP;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_RESP: begin
                    if (memRespReady) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs read as zero throughout reset, including its first cycle
    assign memRespValid = resp_valid_q && !rst;
    assign memRespId    = rst ? '0 : resp_id_q;
    assign memRespData  = rst ? '0 : resp_data_q;

endmodule
`default_nettype wire
